// File: rtl/tdm_dmux8_rx.sv
// 8-lane, 1-bit-slot TDM receiver: hunts for frame_sync, then demuxes 8 slots.
// Define TDM_DMUX8_PARITY_EN to add a 9th even-parity slot checked before out updates.
module tdm_dmux8_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       in_valid,
    input  logic       frame_sync,
    output logic [7:0] out,
    output logic       frame_valid,
    output logic       locked,
    output logic       sync_err,
    output logic       parity_err
);

    typedef enum logic {HUNT, RECV} state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [7:0] r_shadow;
    logic [7:0] r_out;
    logic       r_fv;
    logic       r_se;
    logic       r_pe;

`ifdef TDM_DMUX8_PARITY_EN
    // Even parity: the eight data bits plus the parity bit must xor to zero.
    logic w_par_bad;
    assign w_par_bad = ^{in, r_shadow};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= HUNT;
            r_cnt    <= 4'd0;
            r_shadow <= 8'd0;
            r_out    <= 8'd0;
            r_fv     <= 1'b0;
            r_se     <= 1'b0;
            r_pe     <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            r_se <= 1'b0;
            r_pe <= 1'b0;
            if (in_valid) begin
                unique case (r_state)
                    HUNT: begin
                        if (frame_sync) begin
                            r_shadow[0] <= in;
                            r_cnt       <= 4'd1;
                            r_state     <= RECV;
                        end
                    end
                    RECV: begin
                        if (frame_sync) begin
                            // Early sync restarts the frame at this beat.
                            r_se        <= (r_cnt != 4'd0);
                            r_shadow[0] <= in;
                            r_cnt       <= 4'd1;
                        end else if (r_cnt == 4'd0) begin
                            r_se    <= 1'b1;
                            r_state <= HUNT;
`ifdef TDM_DMUX8_PARITY_EN
                        end else if (r_cnt == 4'd8) begin
                            r_cnt <= 4'd0;
                            if (w_par_bad) begin
                                r_pe <= 1'b1;
                            end else begin
                                r_out <= r_shadow;
                                r_fv  <= 1'b1;
                            end
`else
                        end else if (r_cnt == 4'd7) begin
                            r_out <= {in, r_shadow[6:0]};
                            r_fv  <= 1'b1;
                            r_cnt <= 4'd0;
`endif
                        end else begin
                            r_shadow[r_cnt[2:0]] <= in;
                            r_cnt                <= r_cnt + 4'd1;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign out         = r_out;
    assign frame_valid = r_fv;
    assign locked      = (r_state == RECV);
    assign sync_err    = r_se;
`ifdef TDM_DMUX8_PARITY_EN
    assign parity_err  = r_pe;
`else
    assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_dmux8_rx.sv
// Self-checking bench for tdm_dmux8_rx with a frame scoreboard.
// Adapts to TDM_DMUX8_PARITY_EN by appending the parity slot.
module tb_tdm_dmux8_rx;

`ifdef TDM_DMUX8_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_b = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] out;
    logic       fv;
    logic       locked;
    logic       se;
    logic       pe;

    int n_checks = 0;
    int n_pass = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int pe_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;

    tdm_dmux8_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in         (in_b),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .frame_valid(fv),
        .locked     (locked),
        .sync_err   (se),
        .parity_err (pe)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every frame_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (fv === 1'b1) begin
            fv_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard: unexpected frame_valid, out=%h", out);
            end else begin
                mon_exp = sb.pop_front();
                if (out !== mon_exp)
                    $display("FAIL scoreboard: out=%h expected %h", out, mon_exp);
                else
                    n_pass++;
            end
        end
        if (se === 1'b1) se_cnt++;
        if (pe === 1'b1) pe_cnt++;
        if (int'(fv === 1'b1) + int'(se === 1'b1) + int'(pe === 1'b1) > 1) begin
            n_checks++;
            $display("FAIL pulse_overlap: fv=%b se=%b pe=%b, at most one required",
                     fv, se, pe);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic b, input logic fs);
        in_b       = b;
        frame_sync = fs;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_b       = 1'($urandom);
        frame_sync = 1'($urandom);
    endtask

    task automatic send_frame(input logic [7:0] d, input int gap, input logic bad,
                              output logic first_se, output logic [7:0] first_out,
                              output logic last_fv, output logic last_pe,
                              output logic [7:0] last_out);
        if (!PAR || !bad) sb.push_back(d);
        for (int k = 0; k < 8; k++) begin
            beat(d[k], k == 0);
            if (k == 0) begin
                first_se  = se;
                first_out = out;
            end
            if (k < 7 || PAR) idle(gap);
        end
        if (PAR) beat((^d) ^ bad, 1'b0);
        last_fv  = fv;
        last_pe  = pe;
        last_out = out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(2);
        n_checks++;
        if (out !== 8'h00) $display("FAIL reset_out: out=%h expected 00", out);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b0) $display("FAIL reset_locked: locked=%b expected 0", locked);
        else n_pass++;
        n_checks++;
        if ({fv, se, pe} !== 3'b000)
            $display("FAIL reset_pulses: fv/se/pe=%b expected 000", {fv, se, pe});
        else n_pass++;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_basic;
        logic fse, lfv, lpe;
        logic [7:0] fo, lo;
        send_frame(8'b01001101, 0, 1'b0, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (lfv !== 1'b1) $display("FAIL basic_fv: frame_valid=%b expected 1", lfv);
        else n_pass++;
        n_checks++;
        if (lo !== 8'h4D) $display("FAIL basic_out: out=%h expected 4d", lo);
        else n_pass++;
        n_checks++;
        if (locked !== 1'b1) $display("FAIL basic_locked: locked=%b expected 1", locked);
        else n_pass++;
        n_checks++;
        if (fse !== 1'b0) $display("FAIL basic_se: sync_err=%b expected 0", fse);
        else n_pass++;
        idle(1);
        n_checks++;
        if (fv !== 1'b0) $display("FAIL basic_fv_width: frame_valid=%b expected 0", fv);
        else n_pass++;
    endtask

    task automatic test_gaps;
        logic fse, lfv, lpe;
        logic [7:0] fo, lo;
        int n0;
        send_frame(8'h3C, 0, 1'b0, fse, fo, lfv, lpe, lo);
        idle(1);
        n0 = fv_cnt;
        send_frame(8'h4D, 3, 1'b0, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (fo !== 8'h3C) $display("FAIL gaps_hold: out=%h expected 3c", fo);
        else n_pass++;
        n_checks++;
        if (fv_cnt != n0) $display("FAIL gaps_early_fv: count=%0d expected %0d", fv_cnt, n0);
        else n_pass++;
        n_checks++;
        if (lfv !== 1'b1 || lo !== 8'h4D)
            $display("FAIL gaps_out: fv=%b out=%h expected 1/4d", lfv, lo);
        else n_pass++;
        idle(1);
        n_checks++;
        if (fv_cnt != n0 + 1) $display("FAIL gaps_count: count=%0d expected %0d", fv_cnt, n0 + 1);
        else n_pass++;
    endtask

    task automatic test_early_sync;
        logic fse, lfv, lpe;
        logic [7:0] fo, lo;
        int s0;
        s0 = se_cnt;
        beat(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) beat(1'b1, 1'b0);
        send_frame(8'h96, 0, 1'b0, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (fse !== 1'b1) $display("FAIL early_se: sync_err=%b expected 1", fse);
        else n_pass++;
        n_checks++;
        if (fo !== 8'h4D) $display("FAIL early_hold: out=%h expected 4d", fo);
        else n_pass++;
        n_checks++;
        if (lfv !== 1'b1 || lo !== 8'h96)
            $display("FAIL early_out: fv=%b out=%h expected 1/96", lfv, lo);
        else n_pass++;
        idle(1);
        n_checks++;
        if (se_cnt != s0 + 1) $display("FAIL early_se_count: count=%0d expected %0d", se_cnt, s0 + 1);
        else n_pass++;
    endtask

    task automatic test_missing_sync;
        logic fse, lfv, lpe;
        logic [7:0] fo, lo;
        int s0, f0;
        beat(1'b0, 1'b0);
        n_checks++;
        if (se !== 1'b1 || locked !== 1'b0)
            $display("FAIL miss_se: sync_err=%b locked=%b expected 1/0", se, locked);
        else n_pass++;
        idle(1);
        s0 = se_cnt;
        f0 = fv_cnt;
        for (int k = 0; k < 10; k++) beat(1'($urandom), 1'b0);
        idle(1);
        n_checks++;
        if (locked !== 1'b0 || se_cnt != s0 || fv_cnt != f0)
            $display("FAIL miss_hunt: locked=%b se_cnt=%0d fv_cnt=%0d expected 0/%0d/%0d",
                     locked, se_cnt, fv_cnt, s0, f0);
        else n_pass++;
        send_frame(8'hE1, 1, 1'b0, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (lfv !== 1'b1 || lo !== 8'hE1)
            $display("FAIL miss_relock: fv=%b out=%h expected 1/e1", lfv, lo);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_reset_mid;
        logic fse, lfv, lpe;
        logic [7:0] fo, lo;
        beat(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) beat(1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        n_checks++;
        if (out !== 8'h00 || locked !== 1'b0 || {fv, se, pe} !== 3'b000)
            $display("FAIL midreset: out=%h locked=%b pulses=%b expected 00/0/000",
                     out, locked, {fv, se, pe});
        else n_pass++;
        for (int k = 0; k < 4; k++) beat(1'b1, 1'b0);
        n_checks++;
        if (locked !== 1'b0) $display("FAIL midreset_hunt: locked=%b expected 0", locked);
        else n_pass++;
        send_frame(8'h5A, 0, 1'b0, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (lfv !== 1'b1 || lo !== 8'h5A)
            $display("FAIL midreset_frame: fv=%b out=%h expected 1/5a", lfv, lo);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_parity;
`ifdef TDM_DMUX8_PARITY_EN
        logic fse, lfv, lpe;
        logic [7:0] fo, lo;
        send_frame(8'hA5, 0, 1'b0, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (lfv !== 1'b1 || lpe !== 1'b0 || lo !== 8'hA5)
            $display("FAIL par_good: fv=%b pe=%b out=%h expected 1/0/a5", lfv, lpe, lo);
        else n_pass++;
        send_frame(8'hA5, 0, 1'b1, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (lfv !== 1'b0 || lpe !== 1'b1 || lo !== 8'hA5)
            $display("FAIL par_bad: fv=%b pe=%b out=%h expected 0/1/a5", lfv, lpe, lo);
        else n_pass++;
        send_frame(8'h3C, 0, 1'b1, fse, fo, lfv, lpe, lo);
        n_checks++;
        if (lpe !== 1'b1 || lo !== 8'hA5 || locked !== 1'b1)
            $display("FAIL par_hold: pe=%b out=%h locked=%b expected 1/a5/1", lpe, lo, locked);
        else n_pass++;
        idle(1);
`else
        idle(1);
        n_checks++;
        if (pe_cnt != 0 || pe !== 1'b0)
            $display("FAIL par_tied: parity_err count=%0d expected 0", pe_cnt);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gaps;
        test_early_sync;
        test_missing_sync;
        test_reset_mid;
        test_parity;
        idle(2);
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d frames never seen", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
